// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master.
// Takes one command at a time from a simple valid/ready port and runs it
// as an AXI-Lite write (AW+W, then B) or read (AR, then R). A one-cycle
// rsp_valid pulse reports completion. An optional watchdog abandons a
// transaction that the slave never answers.
module axi_lite_master #(
   parameter int TIMEOUT = 1024
) (
   input  logic        aclk,
   input  logic        aresetn,
   // command side
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   // completion side
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   // write address channel
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   // write data channel
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   // write response channel
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   // read address channel
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   // read data channel
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WADDR_DATA = 3'd1,
      WRESP      = 3'd2,
      RADDR      = 3'd3,
      RDATA      = 3'd4
   } state_t;

   // Counter width covers 0..TIMEOUT; a 1-bit dummy when the watchdog is off.
   localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
   // During cycle k after accept the counter reads k; firing at TIMEOUT-1
   // places the timeout completion pulse exactly TIMEOUT cycles after accept.
   localparam logic [CW-1:0] CLIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, wdata_q;
   logic [3:0]    wstrb_q;
   logic          awvalid_q, wvalid_q, arvalid_q;
   logic [CW-1:0] cnt_q;
   logic          rdy_en_q;
   logic          rsp_valid_q, rsp_timeout_q;
   logic [31:0]   rsp_rdata_q;
   logic [1:0]    rsp_resp_q;

   logic busy, accept;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic tmo_hit, tmo_fire;

   assign busy     = (state_q != IDLE);
   assign accept   = cmd_valid && cmd_ready;
   assign aw_hs    = awvalid_q && m_axi_awready;
   assign w_hs     = wvalid_q  && m_axi_wready;
   assign ar_hs    = arvalid_q && m_axi_arready;
   assign b_hs     = (state_q == WRESP) && m_axi_bvalid;
   assign r_hs     = (state_q == RDATA) && m_axi_rvalid;
   assign tmo_hit  = (TIMEOUT != 0) && busy && (cnt_q >= CLIM);
   // A response arriving in the watchdog's last cycle still completes normally.
   assign tmo_fire = tmo_hit && !b_hs && !r_hs;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (accept) state_d = cmd_write ? WADDR_DATA : RADDR;
         WADDR_DATA: begin
            if (tmo_fire)
               state_d = IDLE;
            else if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
               state_d = WRESP;
         end
         WRESP:      if (b_hs || tmo_fire) state_d = IDLE;
         RADDR: begin
            if (tmo_fire)   state_d = IDLE;
            else if (ar_hs) state_d = RDATA;
         end
         RDATA:      if (r_hs || tmo_fire) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Command capture: the AXI payload comes only from these registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (accept) begin
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         wstrb_q <= cmd_wstrb;
      end
   end

   // Channel valids: raised at accept, each dropped after its own handshake
   // or when the watchdog abandons the transaction.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else if (accept) begin
         awvalid_q <= cmd_write;
         wvalid_q  <= cmd_write;
         arvalid_q <= !cmd_write;
      end else begin
         if (aw_hs || tmo_fire) awvalid_q <= 1'b0;
         if (w_hs  || tmo_fire) wvalid_q  <= 1'b0;
         if (ar_hs || tmo_fire) arvalid_q <= 1'b0;
      end
   end

   // Watchdog: saturating cycle count since accept, cleared while idle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)           cnt_q <= '0;
      else if (accept)        cnt_q <= CW'(1);
      else if (!busy)         cnt_q <= '0;
      else if (cnt_q != CMAX) cnt_q <= cnt_q + CW'(1);
   end

   // Holds cmd_ready low until the first clock edge after reset release.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rdy_en_q <= 1'b0;
      else          rdy_en_q <= 1'b1;
   end

   // Completion pulse and captured response, one cycle after the event.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
      end else begin
         rsp_valid_q   <= b_hs || r_hs || tmo_fire;
         rsp_timeout_q <= tmo_fire;
         if (b_hs) begin
            rsp_rdata_q <= '0;
            rsp_resp_q  <= m_axi_bresp;
         end else if (r_hs) begin
            rsp_rdata_q <= m_axi_rdata;
            rsp_resp_q  <= m_axi_rresp;
         end else if (tmo_fire) begin
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b10;
         end
      end
   end

   assign cmd_ready     = rdy_en_q && (state_q == IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = rsp_timeout_q;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == WRESP);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == RDATA);

endmodule
